wash_session: RTL and testbench
===============================

Name: wash_session

Overview:
- User-side consumer of the per-mode prices and fine that the admin block publishes (dy/s/m/b price, setfine).
- Holds the user balance, charges the selected wash mode, runs a per-second countdown, pauses and fines when the lid opens mid-wash, and drives both 4-digit seven-segment groups through the existing scan4 driver.
- Sits beside the admin block in the top level. Both blocks share clk, rst and the price buses.

Parameters:
- CLK_HZ, 66000000, clock cycles per one-second tick.
- DUR_DY, 8'h20, dry duration, 2-digit BCD seconds.
- DUR_S, 8'h30, small duration, BCD seconds.
- DUR_M, 8'h45, medium duration, BCD seconds.
- DUR_B, 8'h60, big duration, BCD seconds.
- DENY_S, 2, seconds the DENY display is held.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- on  in  1  enable; when low, all state and counters hold
- mode_sel  in  2  0=dry, 1=small, 2=medium, 3=big
- start  in  1  one-cycle pulse (debounced middle button)
- lid_open  in  1  level, 1 = lid open
- bal_load  in  1  one-cycle pulse; loads bal_in as the balance
- bal_in  in  12  3-digit BCD {hundreds,tens,ones}
- dy_price, s_price, m_price, b_price  in  12 each  BCD prices
- setfine  in  12  BCD fine
- bal_out  out  12  current balance, BCD
- remain  out  8  remaining seconds, BCD
- st_out  out  3  state encoding
- done, deny, fine_applied  out  1 each  status flags
- led_r, ena_r  out  8, 4  right display: balance (digits 2..0), digit 3 blank
- led_l, ena_l  out  8, 4  left display: mode digit, blank, remain tens, remain ones

Behaviour:
- Reset (async, rst=0): state IDLE, bal_out=0, remain=0, all flags 0, second-tick counter 0. Display nibbles blank (4'hb) except the balance digits, which show 000.
- Tick: a counter counts 0..CLK_HZ-1 and pulses tick for 1 cycle. The counter is cleared on entry to RUN and DENY. It advances only in RUN and DENY, and only while on=1.
- IDLE (0):
  - bal_load loads bal_in.
  - start with lid_open=0 latches mode and the matching price, then goes to CHECK next cycle.
  - start with lid_open=1 is ignored.
  - bal_load and start in the same cycle: the load wins and start is dropped.
- CHECK (1), one cycle:
  - If bal >= price: bal -= price (BCD subtract), remain = DUR[mode], go to RUN.
  - Otherwise set deny=1 and go to DENY.
- RUN (2):
  - Each tick, remain decrements in BCD (e.g. 10 becomes 09).
  - When remain reaches 00: done=1, go to DONE.
  - lid_open=1 goes to PAUSE with remain frozen.
  - If lid_open and tick occur in the same cycle, PAUSE wins and no decrement happens.
- PAUSE (3):
  - On the first entry per session, if fine_applied=0: set fine_applied=1 and bal -= setfine, saturating at 000. Later pauses in the same session are not fined.
  - lid_open=0 returns to RUN; the tick counter resumes from its held value.
- DONE (4):
  - done stays 1.
  - A rising edge of lid_open goes to IDLE and clears done, fine_applied and remain.
- DENY (5):
  - After DENY_S ticks, clear deny and go to IDLE.
  - bal is unchanged.
- Inputs ignored outside IDLE: start and bal_load.
- Price sampling: the price and fine buses are sampled only at the start latch (price) and at PAUSE entry (fine). Admin changes made mid-session do not affect the current charge.
- on=0: freezes the state, counters and display contents. Pulses that arrive while on=0 are lost.
- BCD rules:
  - All arithmetic is 3-digit BCD with borrow.
  - Compare uses the BCD value (hundreds, then tens, then ones).
  - Inputs with a digit greater than 9 are treated as 9 for that digit.

Decomposition:
- Shared package wm_pkg holds:
  - state encodings IDLE..DENY;
  - mode codes;
  - the blank nibble 4'hb;
  - the BCD digit width.
- Sub-module bcd_sub3: combinational 3-digit BCD subtractor. Inputs a, b. Outputs diff and borrow; on borrow, diff is forced to 000 by the instantiating logic.
- scan4 is reused unchanged, two instances.

Test Plan:
- Reset then bal_load 12'h150, mode 1, s_price 12'h040, start -> CHECK -> RUN; bal_out=12'h110, remain=8'h30. After 30 ticks: done=1, st_out=4.
- bal_in 12'h020, mode 3, b_price 12'h050, start -> deny=1, st_out=5, bal unchanged at 12'h020; IDLE after 2 ticks.
- Run mode 0 (remain=20). At remain=15 assert lid_open for 3 ticks -> remain stays 15, bal reduced once by setfine=12'h010. Close lid, open again -> no second fine.
- bal 12'h005 after the charge, setfine 12'h010, open the lid mid-run -> bal_out saturates to 12'h000, fine_applied=1.
- on=0 during RUN for 2×CLK_HZ cycles -> remain and state unchanged. Raise on -> countdown resumes.
- Assert rst low mid-RUN, asynchronously -> bal_out=0, remain=0, st_out=0, flags 0 before the next clk edge.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared types and BCD helpers for the wash-machine user-side blocks.
package wm_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD2_W  = 2 * DIGIT_W;
  localparam int unsigned BCD3_W  = 3 * DIGIT_W;
  localparam int unsigned ST_W    = 3;

  localparam logic [DIGIT_W-1:0] BLANK = 4'hb;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4,
    ST_DENY  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MODE_DRY = 2'd0,
    MODE_S   = 2'd1,
    MODE_M   = 2'd2,
    MODE_B   = 2'd3
  } mode_t;

  // Any digit above 9 is read as 9.
  function automatic logic [BCD3_W-1:0] bcd_clamp3(input logic [BCD3_W-1:0] v);
    logic [BCD3_W-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[DIGIT_W*i +: DIGIT_W] = (v[DIGIT_W*i +: DIGIT_W] > 4'd9) ? 4'd9 : v[DIGIT_W*i +: DIGIT_W];
    end
    return r;
  endfunction

  function automatic logic [BCD2_W-1:0] bcd_dec2(input logic [BCD2_W-1:0] v);
    logic [BCD2_W-1:0] r;
    if (v[3:0] == 4'd0) r = {4'(v[7:4] - 4'd1), 4'd9};
    else                r = {v[7:4], 4'(v[3:0] - 4'd1)};
    return r;
  endfunction

endpackage

// File: rtl/wash_session_if.sv
// User controls, admin price buses and session status for wash_session.
interface wash_session_if;
  import wm_pkg::*;

  logic              on;
  logic [1:0]        mode_sel;
  logic              start;
  logic              lid_open;
  logic              bal_load;
  logic [BCD3_W-1:0] bal_in;
  logic [BCD3_W-1:0] dy_price;
  logic [BCD3_W-1:0] s_price;
  logic [BCD3_W-1:0] m_price;
  logic [BCD3_W-1:0] b_price;
  logic [BCD3_W-1:0] setfine;
  logic [BCD3_W-1:0] bal_out;
  logic [BCD2_W-1:0] remain;
  logic [ST_W-1:0]   st_out;
  logic              done;
  logic              deny;
  logic              fine_applied;

  modport master (
    output on, mode_sel, start, lid_open, bal_load, bal_in,
           dy_price, s_price, m_price, b_price, setfine,
    input  bal_out, remain, st_out, done, deny, fine_applied
  );

  modport slave (
    input  on, mode_sel, start, lid_open, bal_load, bal_in,
           dy_price, s_price, m_price, b_price, setfine,
    output bal_out, remain, st_out, done, deny, fine_applied
  );

endinterface

// File: rtl/bcd_sub3.sv
// Combinational 3-digit BCD subtractor; borrow set when a < b.
module bcd_sub3
  import wm_pkg::*;
(
  input  logic [BCD3_W-1:0] a,
  input  logic [BCD3_W-1:0] b,
  output logic [BCD3_W-1:0] diff,
  output logic              borrow
);

  always_comb begin
    logic       brw;
    logic [4:0] t;
    brw  = 1'b0;
    t    = '0;
    diff = '0;
    for (int i = 0; i < 3; i++) begin
      t = {1'b0, a[DIGIT_W*i +: DIGIT_W]} - {1'b0, b[DIGIT_W*i +: DIGIT_W]} - {4'b0, brw};
      if (t[4]) begin
        diff[DIGIT_W*i +: DIGIT_W] = 4'(t + 5'd10);
        brw = 1'b1;
      end else begin
        diff[DIGIT_W*i +: DIGIT_W] = t[3:0];
        brw = 1'b0;
      end
    end
    borrow = brw;
  end

endmodule

// File: rtl/scan4.sv
// 4-digit multiplexed seven-segment driver; active-low segments and enables, 4'hb blanks.
module scan4 #(
  parameter int unsigned DIV_W = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  output logic [7:0]  led,
  output logic [3:0]  ena
);

  logic [DIV_W-1:0] div_q;
  logic [1:0]       sel_c;
  logic [3:0]       nib_c;

  assign sel_c = div_q[DIV_W-1 -: 2];

  always_comb begin
    case (sel_c)
      2'd0:    nib_c = digits[3:0];
      2'd1:    nib_c = digits[7:4];
      2'd2:    nib_c = digits[11:8];
      default: nib_c = digits[15:12];
    endcase
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hc0;
      4'd1:    s = 8'hf9;
      4'd2:    s = 8'ha4;
      4'd3:    s = 8'hb0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hf8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hff;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      led   <= 8'hff;
      ena   <= 4'hf;
    end else begin
      div_q <= div_q + 1'b1;
      led   <= seg7(nib_c);
      ena   <= ~(4'b0001 << sel_c);
    end
  end

endmodule

// File: rtl/wash_session.sv
// User-side wash session: balance, charge, countdown, lid pause/fine, and both display groups.
module wash_session
  import wm_pkg::*;
#(
  parameter int unsigned CLK_HZ = 66000000,
  parameter logic [7:0]  DUR_DY = 8'h20,
  parameter logic [7:0]  DUR_S  = 8'h30,
  parameter logic [7:0]  DUR_M  = 8'h45,
  parameter logic [7:0]  DUR_B  = 8'h60,
  parameter int unsigned DENY_S = 2
) (
  input  logic         clk,
  input  logic         rst,
  wash_session_if.slave bus,
  output logic [7:0]   led_r,
  output logic [3:0]   ena_r,
  output logic [7:0]   led_l,
  output logic [3:0]   ena_l
);

  localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DENY_W = (DENY_S > 1) ? $clog2(DENY_S) : 1;
  localparam int unsigned SCAN_W = (CLK_HZ >= 65536) ? 18 : 2;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
  localparam logic [DENY_W-1:0] DENY_LAST = DENY_W'(DENY_S - 1);

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [BCD3_W-1:0] bal_q, bal_d, price_q, price_d;
  logic [BCD3_W-1:0] price_sel_c, sub_b_c, sub_diff_c;
  logic              sub_borrow_c;
  logic [BCD2_W-1:0] remain_q, remain_d, dec_c, dur_c;
  logic              done_q, done_d, deny_q, deny_d, fine_q, fine_d, lid_q, lid_d;
  logic              tick_c;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DENY_W-1:0] deny_cnt_q, deny_cnt_d;

  always_comb begin
    case (bus.mode_sel)
      2'd0:    price_sel_c = bus.dy_price;
      2'd1:    price_sel_c = bus.s_price;
      2'd2:    price_sel_c = bus.m_price;
      default: price_sel_c = bus.b_price;
    endcase
  end

  always_comb begin
    case (mode_q)
      MODE_DRY: dur_c = DUR_DY;
      MODE_S:   dur_c = DUR_S;
      MODE_M:   dur_c = DUR_M;
      default:  dur_c = DUR_B;
    endcase
  end

  // One subtractor serves both the CHECK charge/compare and the PAUSE-entry fine.
  assign sub_b_c = (state_q == ST_RUN) ? bcd_clamp3(bus.setfine) : price_q;
  assign dec_c   = bcd_dec2(remain_q);

  bcd_sub3 u_sub (
    .a      (bal_q),
    .b      (sub_b_c),
    .diff   (sub_diff_c),
    .borrow (sub_borrow_c)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bal_d      = bal_q;
    price_d    = price_q;
    remain_d   = remain_q;
    done_d     = done_q;
    deny_d     = deny_q;
    fine_d     = fine_q;
    lid_d      = lid_q;
    tick_d     = tick_q;
    deny_cnt_d = deny_cnt_q;
    tick_c     = 1'b0;

    if (bus.on) begin
      lid_d  = bus.lid_open;
      tick_c = (((state_q == ST_RUN) && !bus.lid_open) || (state_q == ST_DENY))
               && (tick_q == TICK_LAST);
      unique case (state_q)
        ST_IDLE: begin
          if (bus.bal_load) begin
            bal_d = bcd_clamp3(bus.bal_in);
          end else if (bus.start && !bus.lid_open) begin
            mode_d  = mode_t'(bus.mode_sel);
            price_d = bcd_clamp3(price_sel_c);
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          tick_d = '0;
          if (!sub_borrow_c) begin
            bal_d    = sub_diff_c;
            remain_d = dur_c;
            state_d  = ST_RUN;
          end else begin
            deny_d     = 1'b1;
            deny_cnt_d = '0;
            state_d    = ST_DENY;
          end
        end
        ST_RUN: begin
          if (bus.lid_open) begin
            state_d = ST_PAUSE;
            if (!fine_q) begin
              fine_d = 1'b1;
              bal_d  = sub_borrow_c ? '0 : sub_diff_c;
            end
          end else if (tick_c) begin
            tick_d   = '0;
            remain_d = dec_c;
            if (dec_c == '0) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!bus.lid_open) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (bus.lid_open && !lid_q) begin
            done_d   = 1'b0;
            fine_d   = 1'b0;
            remain_d = '0;
            state_d  = ST_IDLE;
          end
        end
        ST_DENY: begin
          if (tick_c) begin
            tick_d = '0;
            if (deny_cnt_q == DENY_LAST) begin
              deny_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              deny_cnt_d = deny_cnt_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_DRY;
      bal_q      <= '0;
      price_q    <= '0;
      remain_q   <= '0;
      done_q     <= 1'b0;
      deny_q     <= 1'b0;
      fine_q     <= 1'b0;
      lid_q      <= 1'b0;
      tick_q     <= '0;
      deny_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bal_q      <= bal_d;
      price_q    <= price_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      deny_q     <= deny_d;
      fine_q     <= fine_d;
      lid_q      <= lid_d;
      tick_q     <= tick_d;
      deny_cnt_q <= deny_cnt_d;
    end
  end

  assign bus.bal_out      = bal_q;
  assign bus.remain       = remain_q;
  assign bus.st_out       = state_q;
  assign bus.done         = done_q;
  assign bus.deny         = deny_q;
  assign bus.fine_applied = fine_q;

  // Left group: mode once a session starts, remaining seconds while a wash is under way.
  logic [15:0] disp_r_c, disp_l_c;
  logic        show_rem_c;
  assign show_rem_c = (state_q == ST_RUN) || (state_q == ST_PAUSE) || (state_q == ST_DONE);
  assign disp_r_c   = {BLANK, bal_q};
  assign disp_l_c   = {(state_q == ST_IDLE) ? BLANK : {2'b00, mode_q},
                       BLANK,
                       show_rem_c ? remain_q : {BLANK, BLANK}};

  scan4 #(.DIV_W(SCAN_W)) u_scan_r (
    .clk    (clk),
    .rst    (rst),
    .digits (disp_r_c),
    .led    (led_r),
    .ena    (ena_r)
  );

  scan4 #(.DIV_W(SCAN_W)) u_scan_l (
    .clk    (clk),
    .rst    (rst),
    .digits (disp_l_c),
    .led    (led_l),
    .ena    (ena_l)
  );

endmodule

// File: tb/tb_wash_session.sv
// Bench for wash_session: IDLE vector table, directed session sequences, and a random run against an integer model.
module tb_wash_session;

  localparam int unsigned HZ = 10;
  localparam int unsigned DENY_TICKS = 2;
  localparam logic [7:0] SEG_0 = 8'hc0;
  localparam logic [7:0] SEG_1 = 8'hf9;
  localparam logic [7:0] SEG_BL = 8'hff;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_r, led_l;
  logic [3:0] ena_r, ena_l;

  wash_session_if bus();

  wash_session #(.CLK_HZ(HZ), .DENY_S(DENY_TICKS)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .led_r (led_r),
    .ena_r (ena_r),
    .led_l (led_l),
    .ena_l (ena_l)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.on = 1'b1; bus.start = 1'b0; bus.bal_load = 1'b0; bus.lid_open = 1'b0;
    bus.mode_sel = 2'd0; bus.bal_in = '0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic pulse_load(input logic [11:0] v);
    bus.bal_in = v; bus.bal_load = 1'b1;
    step();
    bus.bal_load = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    bus.mode_sel = m; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_st(input string name, input logic [2:0] st, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (bus.st_out == st) hit = 1'b1;
      else step();
    end
    chk(name, 32'(hit), 1);
  endtask

  task automatic wait_rem(input string name, input logic [7:0] r, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (bus.remain == r) hit = 1'b1;
      else step();
    end
    chk(name, 32'(hit), 1);
  endtask

  task automatic chk_scan(input string name, input bit left, input int dig, input logic [7:0] exp);
    logic [3:0] want;
    logic [7:0] got;
    bit hit;
    want = ~(4'b0001 << dig);
    got = 'x;
    hit = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      @(negedge clk);
      if ((left ? ena_l : ena_r) == want) begin
        hit = 1'b1;
        got = left ? led_l : led_r;
      end
    end
    chk(name, 32'(got), 32'(exp));
  endtask

  // Integer model: balance and seconds held as plain numbers, phases numbered as the visible st_out.
  localparam int PH_IDLE = 0, PH_CHECK = 1, PH_RUN = 2, PH_PAUSE = 3, PH_DONE = 4, PH_DENY = 5;
  int dur_tab [4] = '{20, 30, 45, 60};
  int m_ph, m_bal, m_rem, m_price, m_mode, m_cnt, m_dn;
  bit m_done, m_deny, m_fine, m_lid;

  function automatic int b2i(input logic [11:0] v);
    int h, t, o;
    h = int'(v[11:8]); t = int'(v[7:4]); o = int'(v[3:0]);
    if (h > 9) h = 9;
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return h * 100 + t * 10 + o;
  endfunction

  function automatic logic [11:0] i2b(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] rand_bcd();
    if ($urandom_range(0, 4) == 0) return 12'($urandom_range(0, 4095));
    return i2b(int'($urandom_range(0, 999)));
  endfunction

  function automatic logic [11:0] rand_price();
    if ($urandom_range(0, 6) == 0) return 12'($urandom_range(0, 4095));
    return i2b(int'($urandom_range(0, 120)));
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_bal = 0; m_rem = 0; m_price = 0; m_mode = 0; m_cnt = 0; m_dn = 0;
    m_done = 0; m_deny = 0; m_fine = 0; m_lid = 0;
  endtask

  task automatic model_step();
    bit prev, lid, second;
    int p;
    if (!bus.on) return;
    lid = bus.lid_open;
    prev = m_lid;
    m_lid = lid;
    second = (m_cnt == HZ - 1) && ((m_ph == PH_RUN && !lid) || m_ph == PH_DENY);
    case (m_ph)
      PH_IDLE: begin
        if (bus.bal_load) m_bal = b2i(bus.bal_in);
        else if (bus.start && !lid) begin
          m_mode = int'(bus.mode_sel);
          case (m_mode)
            0: p = b2i(bus.dy_price);
            1: p = b2i(bus.s_price);
            2: p = b2i(bus.m_price);
            default: p = b2i(bus.b_price);
          endcase
          m_price = p;
          m_ph = PH_CHECK;
        end
      end
      PH_CHECK: begin
        m_cnt = 0;
        if (m_bal >= m_price) begin
          m_bal -= m_price; m_rem = dur_tab[m_mode]; m_ph = PH_RUN;
        end else begin
          m_deny = 1; m_dn = 0; m_ph = PH_DENY;
        end
      end
      PH_RUN: begin
        if (lid) begin
          m_ph = PH_PAUSE;
          if (!m_fine) begin
            m_fine = 1;
            m_bal = m_bal - b2i(bus.setfine);
            if (m_bal < 0) m_bal = 0;
          end
        end else if (second) begin
          m_cnt = 0; m_rem--;
          if (m_rem == 0) begin m_done = 1; m_ph = PH_DONE; end
        end else m_cnt++;
      end
      PH_PAUSE: if (!lid) m_ph = PH_RUN;
      PH_DONE: if (lid && !prev) begin
        m_ph = PH_IDLE; m_done = 0; m_fine = 0; m_rem = 0;
      end
      default: begin
        if (second) begin
          m_cnt = 0; m_dn++;
          if (m_dn == DENY_TICKS) begin m_deny = 0; m_ph = PH_IDLE; end
        end else m_cnt++;
      end
    endcase
  endtask

  typedef struct {
    logic        load;
    logic [11:0] bal_in;
    logic        start;
    logic        lid;
    logic [1:0]  mode;
    logic [11:0] exp_bal;
    logic [2:0]  exp_st;
    logic [7:0]  exp_rem;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0]  r0;
    logic [11:0] tmp;
    bit          hit;

    vecs[0] = '{1'b1, 12'h150, 1'b0, 1'b0, 2'd0, 12'h150, 3'd0, 8'h00};
    vecs[1] = '{1'b1, 12'h1fa, 1'b0, 1'b0, 2'd0, 12'h199, 3'd0, 8'h00};
    vecs[2] = '{1'b1, 12'h250, 1'b1, 1'b0, 2'd1, 12'h250, 3'd0, 8'h00};
    vecs[3] = '{1'b0, 12'h000, 1'b1, 1'b1, 2'd1, 12'h250, 3'd0, 8'h00};
    vecs[4] = '{1'b0, 12'h000, 1'b1, 1'b0, 2'd1, 12'h250, 3'd1, 8'h00};
    vecs[5] = '{1'b0, 12'h000, 1'b0, 1'b0, 2'd1, 12'h210, 3'd2, 8'h30};

    bus.dy_price = 12'h010; bus.s_price = 12'h040; bus.m_price = 12'h070;
    bus.b_price = 12'h050; bus.setfine = 12'h010;
    do_reset();

    chk("rst_bal", 32'(bus.bal_out), 0);
    chk("rst_remain", 32'(bus.remain), 0);
    chk("rst_st", 32'(bus.st_out), 0);
    chk("rst_flags", 32'({bus.done, bus.deny, bus.fine_applied}), 0);
    chk_scan("rst_disp_r0", 1'b0, 0, SEG_0);
    chk_scan("rst_disp_r3", 1'b0, 3, SEG_BL);
    chk_scan("rst_disp_l3", 1'b1, 3, SEG_BL);

    // IDLE input handling, one cycle per vector
    for (int i = 0; i < 6; i++) begin
      bus.bal_load = vecs[i].load; bus.bal_in = vecs[i].bal_in; bus.start = vecs[i].start;
      bus.lid_open = vecs[i].lid; bus.mode_sel = vecs[i].mode;
      step();
      bus.bal_load = 1'b0; bus.start = 1'b0; bus.lid_open = 1'b0;
      chk($sformatf("vec%0d_bal", i), 32'(bus.bal_out), 32'(vecs[i].exp_bal));
      chk($sformatf("vec%0d_st", i), 32'(bus.st_out), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d_remain", i), 32'(bus.remain), 32'(vecs[i].exp_rem));
    end

    // Small wash to completion
    do_reset();
    pulse_load(12'h150);
    pulse_start(2'd1);
    chk("c_check_st", 32'(bus.st_out), 1);
    step();
    chk("c_run_st", 32'(bus.st_out), 2);
    chk("c_bal", 32'(bus.bal_out), 'h110);
    chk("c_remain", 32'(bus.remain), 'h30);
    chk_scan("c_disp_mode", 1'b1, 3, SEG_1);
    chk_scan("c_disp_gap", 1'b1, 2, SEG_BL);
    step();
    wait_st("c_reach_done", 3'd4, 400);
    chk("c_done", 32'(bus.done), 1);
    chk("c_remain0", 32'(bus.remain), 0);

    // Lid rising edge leaves DONE, then an underfunded start is denied
    bus.lid_open = 1'b1;
    step();
    chk("d_exit_st", 32'(bus.st_out), 0);
    chk("d_exit_done", 32'(bus.done), 0);
    bus.lid_open = 1'b0;
    step();
    pulse_load(12'h020);
    pulse_start(2'd3);
    chk("d_check_st", 32'(bus.st_out), 1);
    step();
    chk("d_deny_st", 32'(bus.st_out), 5);
    chk("d_deny_flag", 32'(bus.deny), 1);
    chk("d_deny_bal", 32'(bus.bal_out), 'h020);
    step(2 * HZ - 1);
    chk("d_deny_hold", 32'(bus.st_out), 5);
    step();
    chk("d_idle_st", 32'(bus.st_out), 0);
    chk("d_idle_deny", 32'(bus.deny), 0);
    chk("d_idle_bal", 32'(bus.bal_out), 'h020);

    // Dry wash, pause at 15 with a single fine
    pulse_load(12'h100);
    pulse_start(2'd0);
    step();
    chk("e_bal", 32'(bus.bal_out), 'h090);
    chk("e_remain", 32'(bus.remain), 'h20);
    wait_rem("e_reach15", 8'h15, 100);
    bus.lid_open = 1'b1;
    step(3 * HZ);
    chk("e_pause_st", 32'(bus.st_out), 3);
    chk("e_pause_remain", 32'(bus.remain), 'h15);
    chk("e_fine_bal", 32'(bus.bal_out), 'h080);
    chk("e_fine_flag", 32'(bus.fine_applied), 1);
    bus.lid_open = 1'b0;
    step(3);
    chk("e_resume_st", 32'(bus.st_out), 2);
    bus.lid_open = 1'b1;
    step(3);
    chk("e_repause_st", 32'(bus.st_out), 3);
    chk("e_no_second_fine", 32'(bus.bal_out), 'h080);
    bus.lid_open = 1'b0;
    step();
    wait_st("e_reach_done", 3'd4, 300);
    bus.lid_open = 1'b1;
    step();
    chk("e_exit_st", 32'(bus.st_out), 0);
    chk("e_exit_fine", 32'(bus.fine_applied), 0);
    chk("e_exit_remain", 32'(bus.remain), 0);
    bus.lid_open = 1'b0;
    step();

    // Fine larger than the remaining balance saturates at zero
    do_reset();
    pulse_load(12'h015);
    pulse_start(2'd0);
    step();
    chk("f_bal", 32'(bus.bal_out), 'h005);
    step(5);
    bus.lid_open = 1'b1;
    step();
    chk("f_sat_bal", 32'(bus.bal_out), 0);
    chk("f_sat_flag", 32'(bus.fine_applied), 1);
    bus.lid_open = 1'b0;
    step();
    chk("f_resume_st", 32'(bus.st_out), 2);

    // on=0 freezes the countdown
    r0 = bus.remain;
    bus.on = 1'b0;
    step(2 * HZ);
    chk("g_hold_remain", 32'(bus.remain), 32'(r0));
    chk("g_hold_st", 32'(bus.st_out), 2);
    bus.on = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < HZ + 2 && !hit; i++) begin
      step();
      if (bus.remain != r0) hit = 1'b1;
    end
    tmp = i2b(b2i({4'h0, r0}) - 1);
    chk("g_resume_remain", 32'(bus.remain), 32'(tmp[7:0]));

    // Asynchronous reset mid-run, observed before the next clock edge
    rst = 1'b0;
    #1;
    chk("h_bal", 32'(bus.bal_out), 0);
    chk("h_remain", 32'(bus.remain), 0);
    chk("h_st", 32'(bus.st_out), 0);
    chk("h_flags", 32'({bus.done, bus.deny, bus.fine_applied}), 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Random traffic against the integer model
    do_reset();
    model_reset();
    for (int c = 0; c < 6000; c++) begin
      logic [11:0] mb, mr;
      bus.on = ($urandom_range(0, 9) != 0);
      bus.start = ($urandom_range(0, 15) == 0);
      bus.bal_load = ($urandom_range(0, 40) == 0);
      bus.bal_in = rand_bcd();
      bus.mode_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 60) == 0) bus.lid_open = ~bus.lid_open;
      if ($urandom_range(0, 30) == 0) begin
        bus.dy_price = rand_price(); bus.s_price = rand_price();
        bus.m_price = rand_price(); bus.b_price = rand_price();
        bus.setfine = rand_price();
      end
      model_step();
      step();
      mb = i2b(m_bal);
      mr = i2b(m_rem);
      chk($sformatf("rand_c%0d", c),
          32'({bus.bal_out, bus.remain, bus.st_out, bus.done, bus.deny, bus.fine_applied}),
          32'({mb, mr[7:0], 3'(m_ph), m_done, m_deny, m_fine}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
